// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared level encodings, board sizes and placer FSM states
package game_pkg;

  localparam logic [1:0] LVL_NONE   = 2'd0;
  localparam logic [1:0] LVL_EASY   = 2'd1;
  localparam logic [1:0] LVL_MEDIUM = 2'd2;
  localparam logic [1:0] LVL_HARD   = 2'd3;

  localparam int SIZE_EASY   = 8;
  localparam int SIZE_MEDIUM = 10;
  localparam int SIZE_HARD   = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRAW,
    CHECK,
    FIN
  } place_state_t;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  // Right-shifting Galois form; a nonzero seed keeps it off the all-zero lockup state.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - places a fixed number of distinct mines, avoiding the safe field
module mine_placer
  import game_pkg::*;
#(
  parameter int          MINES_EASY   = 10,
  parameter int          MINES_MEDIUM = 16,
  parameter int          MINES_HARD   = 40,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          level,
  input  logic [4:0]          safe_x,
  input  logic [4:0]          safe_y,
  output logic                busy,
  output logic                done,
  output logic [7:0]          mine_cnt,
  output logic [7:0][7:0]     mine_arr_easy,
  output logic [9:0][9:0]     mine_arr_medium,
  output logic [15:0][15:0]   mine_arr_hard
);

  place_state_t state, state_next;

  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic [1:0]  lvl_q;
  logic [4:0]  sx_q, sy_q;
  logic [7:0]  target_q;
  logic [3:0]  cx, cy;
  logic        accept_start;
  logic        out_of_range;
  logic        occupied;
  logic        reject;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  // Only the low byte feeds candidate coordinates.
  assign lfsr_unused  = ^lfsr[15:8];
  assign accept_start = start && (level != LVL_NONE);

  always_comb begin
    out_of_range = 1'b0;
    occupied     = 1'b0;
    case (lvl_q)
      LVL_EASY:   occupied = mine_arr_easy[cx[2:0]][cy[2:0]];
      LVL_MEDIUM: begin
        out_of_range = (cx >= 4'(SIZE_MEDIUM)) || (cy >= 4'(SIZE_MEDIUM));
        occupied     = out_of_range ? 1'b0 : mine_arr_medium[cx][cy];
      end
      LVL_HARD:   occupied = mine_arr_hard[cx][cy];
      default:    occupied = 1'b0;
    endcase
    reject = out_of_range || occupied ||
             (({1'b0, cx} == sx_q) && ({1'b0, cy} == sy_q));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_start) state_next = CLEAR;
      CLEAR:   state_next = DRAW;
      DRAW:    state_next = CHECK;
      CHECK: begin
        if (reject)                                state_next = DRAW;
        else if ((mine_cnt + 8'd1) == target_q)    state_next = FIN;
        else                                       state_next = DRAW;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      mine_cnt        <= 8'd0;
      mine_arr_easy   <= '0;
      mine_arr_medium <= '0;
      mine_arr_hard   <= '0;
      lvl_q           <= LVL_NONE;
      sx_q            <= 5'd0;
      sy_q            <= 5'd0;
      target_q        <= 8'd0;
      cx              <= 4'd0;
      cy              <= 4'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next == CLEAR) || (state_next == DRAW) || (state_next == CHECK);
      done  <= (state_next == FIN);
      case (state)
        IDLE: begin
          if (accept_start) begin
            lvl_q <= level;
            sx_q  <= safe_x;
            sy_q  <= safe_y;
            case (level)
              LVL_EASY:   target_q <= 8'(MINES_EASY);
              LVL_MEDIUM: target_q <= 8'(MINES_MEDIUM);
              default:    target_q <= 8'(MINES_HARD);
            endcase
          end
        end
        CLEAR: begin
          mine_arr_easy   <= '0;
          mine_arr_medium <= '0;
          mine_arr_hard   <= '0;
          mine_cnt        <= 8'd0;
        end
        DRAW: begin
          if (lvl_q == LVL_EASY) begin
            cx <= {1'b0, lfsr[2:0]};
            cy <= {1'b0, lfsr[5:3]};
          end else begin
            cx <= lfsr[3:0];
            cy <= lfsr[7:4];
          end
        end
        CHECK: begin
          if (!reject) begin
            case (lvl_q)
              LVL_EASY:   mine_arr_easy[cx[2:0]][cy[2:0]] <= 1'b1;
              LVL_MEDIUM: mine_arr_medium[cx][cy]         <= 1'b1;
              default:    mine_arr_hard[cx][cy]           <= 1'b1;
            endcase
            mine_cnt <= mine_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// tb/tb_mine_placer.sv - table-driven self-checking bench for mine_placer
module tb_mine_placer;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [1:0]          level;
  logic [4:0]          safe_x, safe_y;
  logic                busy, done;
  logic [7:0]          mine_cnt;
  logic [7:0][7:0]     mine_arr_easy;
  logic [9:0][9:0]     mine_arr_medium;
  logic [15:0][15:0]   mine_arr_hard;

  int n_total = 0;
  int n_pass  = 0;
  int done_total = 0;
  int overlap = 0;

  mine_placer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .level           (level),
    .safe_x          (safe_x),
    .safe_y          (safe_y),
    .busy            (busy),
    .done            (done),
    .mine_cnt        (mine_cnt),
    .mine_arr_easy   (mine_arr_easy),
    .mine_arr_medium (mine_arr_medium),
    .mine_arr_hard   (mine_arr_hard)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_total++;
    if (busy && done) overlap++;
  end

  typedef struct {
    logic [1:0] lvl;
    int sx, sy;
    int exp_easy, exp_med, exp_hard;
    int min_lat;
    bit chk_safe;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int pop(input logic [255:0] v);
    int c = 0;
    for (int i = 0; i < 256; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int get_bit(input logic [1:0] lvl, input int x, input int y);
    case (lvl)
      2'd1:    return int'(mine_arr_easy[x][y]);
      2'd2:    return int'(mine_arr_medium[x][y]);
      default: return int'(mine_arr_hard[x][y]);
    endcase
  endfunction

  // Starts a run, scrambles the inputs afterwards, optionally re-pulses start mid-run.
  task automatic run_game(input logic [1:0] lvl, input int sx, input int sy,
                          input bit extra_start, output int lat, output int ndone);
    int d0;
    @(negedge clk);
    level  = lvl;
    safe_x = 5'(sx);
    safe_y = 5'(sy);
    start  = 1'b1;
    d0  = done_total;
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        start  = 1'b0;
        level  = 2'(lvl + 2'd1);
        safe_x = 5'd31;
        safe_y = 5'd31;
      end
      if (extra_start && lat == 10) start = 1'b1;
      if (extra_start && lat == 11) start = 1'b0;
      if (done) break;
      if (lat >= 20000) begin
        check("run_timeout", lat, -1);
        break;
      end
    end
    repeat (5) @(negedge clk);
    ndone = done_total - d0;
    level = 2'd0;
  endtask

  initial begin
    int lat, nd, bsy, d0, guard;

    vecs[0] = '{2'd1, 3, 4,   10, 0,  0,  22, 1'b1};
    vecs[1] = '{2'd2, 9, 9,   0,  16, 0,  34, 1'b1};
    vecs[2] = '{2'd3, 0, 0,   0,  0,  40, 82, 1'b1};
    vecs[3] = '{2'd1, 20, 20, 10, 0,  0,  22, 1'b0};
    vecs[4] = '{2'd2, 0, 5,   0,  16, 0,  34, 1'b1};

    rst = 1'b1; start = 1'b0; level = 2'd0; safe_x = 5'd0; safe_y = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("reset_easy", pop(256'(mine_arr_easy)), 0);
    check("reset_med",  pop(256'(mine_arr_medium)), 0);
    check("reset_hard", pop(256'(mine_arr_hard)), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_cnt",  int'(mine_cnt), 0);

    for (int i = 0; i < 5; i++) begin
      run_game(vecs[i].lvl, vecs[i].sx, vecs[i].sy, vecs[i].lvl == 2'd3, lat, nd);
      check($sformatf("v%0d_done_once", i), nd, 1);
      check($sformatf("v%0d_lat_min", i), int'(lat >= vecs[i].min_lat), 1);
      check($sformatf("v%0d_pop_easy", i), pop(256'(mine_arr_easy)), vecs[i].exp_easy);
      check($sformatf("v%0d_pop_med", i),  pop(256'(mine_arr_medium)), vecs[i].exp_med);
      check($sformatf("v%0d_pop_hard", i), pop(256'(mine_arr_hard)), vecs[i].exp_hard);
      check($sformatf("v%0d_cnt", i), int'(mine_cnt),
            vecs[i].exp_easy + vecs[i].exp_med + vecs[i].exp_hard);
      check($sformatf("v%0d_busy_after", i), int'(busy), 0);
      if (vecs[i].chk_safe)
        check($sformatf("v%0d_safe_bit", i), get_bit(vecs[i].lvl, vecs[i].sx, vecs[i].sy), 0);
    end

    // level 0 start must be ignored; previous medium board must survive
    d0 = done_total;
    bsy = 0;
    @(negedge clk);
    level = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy) bsy++;
    end
    check("lvl0_busy", bsy, 0);
    check("lvl0_done", done_total - d0, 0);
    check("lvl0_pop_med", pop(256'(mine_arr_medium)), 16);
    check("lvl0_pop_easy", pop(256'(mine_arr_easy)), 0);
    check("lvl0_pop_hard", pop(256'(mine_arr_hard)), 0);

    // reset in the middle of a hard run
    @(negedge clk);
    level = 2'd3; safe_x = 5'd0; safe_y = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; level = 2'd0;
    guard = 0;
    while (mine_cnt < 8'd20 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("midrst_reached20", int'(mine_cnt >= 8'd20), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_pop_hard", pop(256'(mine_arr_hard)), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_cnt", int'(mine_cnt), 0);
    rst = 1'b0;
    run_game(2'd3, 7, 7, 1'b0, lat, nd);
    check("post_rst_done_once", nd, 1);
    check("post_rst_pop_hard", pop(256'(mine_arr_hard)), 40);
    check("post_rst_cnt", int'(mine_cnt), 40);
    check("post_rst_safe", get_bit(2'd3, 7, 7), 0);
    check("busy_done_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
